mult_div_unit: RTL

Parametrised successor to the P6 multiply/divide unit, sitting in the E stage beside the ALU and owning the HI/LO registers.
- Supports signed/unsigned multiply and divide, plus MTHI/MTLO.
- Latencies are configurable per operation class.
- A cancel input lets the pipeline abort an in-flight operation on exception/flush.
- Optional multiply-accumulate operations.

---
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - operand/command/result bundle for the multiply/divide unit
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       md_op;
  logic             start;
  logic             cancel;
  logic             busy;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, md_op, start, cancel,
    input  busy, div_zero, hi, lo
  );

  modport slave (
    input  a, b, md_op, start, cancel,
    output busy, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage multiply/divide unit owning HI/LO; MADD/MSUB family enabled by MULT_DIV_MACC_EN
module mult_div_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave md
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULT_DIV_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] t_hi_q;
  logic [WIDTH-1:0] t_lo_q;
  logic             t_div_q;
  logic             t_zero_q;

  logic [2*WIDTH-1:0] a_sext, b_sext, a_zext, b_zext;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag, b_mag_safe, b_u_safe;
  logic [WIDTH-1:0]   qs_mag, rs_mag, qs, rs, qu, ru;

  logic             launch_mul, launch_div;
  logic [WIDTH-1:0] res_hi_d, res_lo_d;

  // Full-width products; the signed one wraps modulo 2^(2*WIDTH) on sign-extended operands
  always_comb begin
    a_sext = {{WIDTH{md.a[WIDTH-1]}}, md.a};
    b_sext = {{WIDTH{md.b[WIDTH-1]}}, md.b};
    a_zext = {{WIDTH{1'b0}}, md.a};
    b_zext = {{WIDTH{1'b0}}, md.b};
    prod_s = a_sext * b_sext;
    prod_u = a_zext * b_zext;
  end

  // Quotient/remainder; signed divide works on magnitudes so most-negative / -1 wraps to most-negative
  always_comb begin
    b_zero     = (md.b == '0);
    a_neg      = md.a[WIDTH-1];
    b_neg      = md.b[WIDTH-1];
    a_mag      = a_neg ? -md.a : md.a;
    b_mag      = b_neg ? -md.b : md.b;
    b_mag_safe = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    b_u_safe   = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : md.b;
    qs_mag     = a_mag / b_mag_safe;
    rs_mag     = a_mag % b_mag_safe;
    qs         = (a_neg ^ b_neg) ? -qs_mag : qs_mag;
    rs         = a_neg ? -rs_mag : rs_mag;
    qu         = md.a / b_u_safe;
    ru         = md.a % b_u_safe;
  end

  // Decode the requested op into an operation class and its precomputed HI/LO result
  always_comb begin
    launch_mul = 1'b0;
    launch_div = 1'b0;
    res_hi_d   = '0;
    res_lo_d   = '0;
    case (md.md_op)
      OP_MULT:  begin launch_mul = 1'b1; {res_hi_d, res_lo_d} = prod_s; end
      OP_MULTU: begin launch_mul = 1'b1; {res_hi_d, res_lo_d} = prod_u; end
      OP_DIV:   begin launch_div = 1'b1; res_hi_d = rs; res_lo_d = qs; end
      OP_DIVU:  begin launch_div = 1'b1; res_hi_d = ru; res_lo_d = qu; end
`ifdef MULT_DIV_MACC_EN
      OP_MADD:  begin launch_mul = 1'b1; {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_s; end
      OP_MADDU: begin launch_mul = 1'b1; {res_hi_d, res_lo_d} = {hi_q, lo_q} + prod_u; end
      OP_MSUB:  begin launch_mul = 1'b1; {res_hi_d, res_lo_d} = {hi_q, lo_q} - prod_s; end
      OP_MSUBU: begin launch_mul = 1'b1; {res_hi_d, res_lo_d} = {hi_q, lo_q} - prod_u; end
`endif
      default: ;
    endcase
  end

  // Control FSM: accept in IDLE, count down in RUN, write HI/LO on the last busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      t_hi_q   <= '0;
      t_lo_q   <= '0;
      t_div_q  <= 1'b0;
      t_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md.start && !md.cancel) begin
            if (launch_mul || launch_div) begin
              state_q  <= S_RUN;
              busy_q   <= 1'b1;
              cnt_q    <= launch_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
              t_hi_q   <= res_hi_d;
              t_lo_q   <= res_lo_d;
              t_div_q  <= launch_div;
              t_zero_q <= launch_div && b_zero;
            end else if (md.md_op == OP_MTHI) begin
              hi_q <= md.a;
            end else if (md.md_op == OP_MTLO) begin
              lo_q <= md.a;
            end
          end
        end
        S_RUN: begin
          if (md.cancel) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == CW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (!t_div_q) begin
              hi_q <= t_hi_q;
              lo_q <= t_lo_q;
            end else if (t_zero_q) begin
              dz_q <= 1'b1;
            end else begin
              hi_q <= t_hi_q;
              lo_q <= t_lo_q;
              dz_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md.busy     = busy_q;
  assign md.div_zero = dz_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule
